// File: rtl/f32_op_scheduler_if.sv
// Handshake bundle between the requesters, the op scheduler and the shared float32 adder-subtractor.
// slave = scheduler side; master = requesters plus the datapath they share.
interface f32_op_scheduler_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_op;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [31:0]         rsp_r;
  logic                rsp_overflow;
  logic                rsp_underflow;
  logic [31:0]         dp_a;
  logic [31:0]         dp_b;
  logic                dp_op;
  logic [31:0]         dp_r;
  logic                dp_overflow;
  logic                dp_underflow;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, dp_r, dp_overflow, dp_underflow,
    output req_ready, rsp_valid, rsp_r, rsp_overflow, rsp_underflow, dp_a, dp_b, dp_op
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, dp_r, dp_overflow, dp_underflow,
    input  req_ready, rsp_valid, rsp_r, rsp_overflow, rsp_underflow, dp_a, dp_b, dp_op
  );
endinterface

// File: rtl/f32_op_scheduler.sv
// Round-robin scheduler sharing one float32 adder-subtractor between N_REQ requesters:
// grant, drive operands, wait LATENCY cycles, then hand the captured result back to the winner.
module f32_op_scheduler #(
  parameter int N_REQ   = 2,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  f32_op_scheduler_if.slave   bus_io,
  output logic                busy_o,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic [CNT_W-1:0]    op_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       dp_a_q, dp_a_d;
  logic [31:0]       dp_b_q, dp_b_d;
  logic              dp_op_q, dp_op_d;
  logic [31:0]       rsp_r_q, rsp_r_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_unf_q, rsp_unf_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic              busy_q;
  logic [N_REQ-1:0]  grant_vec;

  // Candidate gi is the (gi+1)-th requester after the last winner, so index 0 has top priority.
  logic [IDX_W-1:0]  cand_idx [N_REQ];
  logic [N_REQ-1:0]  cand_valid;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand_idx[gi]   = IDX_W'((int'(ptr_q) + gi + 1) % N_REQ);
    assign cand_valid[gi] = bus_io.req_valid[cand_idx[gi]];
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    dp_op_d     = dp_op_q;
    rsp_r_d     = rsp_r_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_unf_d   = rsp_unf_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    grant_vec   = '0;

    unique case (state_q)
      S_IDLE: begin
        // Ready only goes to a valid requester, so a grant is always a transfer.
        if (win_found && !rst_i) begin
          grant_vec[win_idx] = 1'b1;
          dp_a_d  = bus_io.req_a[32*int'(win_idx) +: 32];
          dp_b_d  = bus_io.req_b[32*int'(win_idx) +: 32];
          dp_op_d = bus_io.req_op[win_idx];
          grant_d = win_idx;
          cnt_d   = LAT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_r_d              = bus_io.dp_r;
          rsp_ovf_d            = bus_io.dp_overflow;
          rsp_unf_d            = bus_io.dp_underflow;
          rsp_valid_d          = '0;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (bus_io.rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          ptr_d       = grant_q;
          op_count_d  = op_count_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDX_W'(N_REQ - 1);
      grant_q     <= '0;
      cnt_q       <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_op_q     <= 1'b0;
      rsp_r_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
      rsp_valid_q <= '0;
      op_count_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_op_q     <= dp_op_d;
      rsp_r_q     <= rsp_r_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_unf_q   <= rsp_unf_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus_io.req_ready     = grant_vec;
  assign bus_io.rsp_valid     = rsp_valid_q;
  assign bus_io.rsp_r         = rsp_r_q;
  assign bus_io.rsp_overflow  = rsp_ovf_q;
  assign bus_io.rsp_underflow = rsp_unf_q;
  assign bus_io.dp_a          = dp_a_q;
  assign bus_io.dp_b          = dp_b_q;
  assign bus_io.dp_op         = dp_op_q;
  assign busy_o               = busy_q;
  assign grant_idx_o          = grant_q;
  assign op_count_o           = op_count_q;

endmodule

// File: tb/tb_f32_op_scheduler.sv
// Bench for f32_op_scheduler: instance A (LATENCY=3, CNT_W=16) and instance B (LATENCY=1, CNT_W=4),
// each driven against a behavioural datapath stub; responses are checked from a queue of expected results.
`timescale 1ns/1ps
module tb_f32_op_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, rst_b;
  logic        busy_a, busy_b;
  logic [0:0]  gidx_a, gidx_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          idx;
    logic [31:0] r;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  f32_op_scheduler_if #(.N_REQ(2)) ia ();
  f32_op_scheduler_if #(.N_REQ(2)) ib ();

  f32_op_scheduler #(.N_REQ(2), .LATENCY(3), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus_io(ia),
    .busy_o(busy_a), .grant_idx_o(gidx_a), .op_count_o(cnt_a)
  );

  f32_op_scheduler #(.N_REQ(2), .LATENCY(1), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus_io(ib),
    .busy_o(busy_b), .grant_idx_o(gidx_b), .op_count_o(cnt_b)
  );

  // Datapath stub: exact float results for the operands used in directed tests, a tag otherwise.
  function automatic logic [31:0] dp_res(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && !op) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h3F800000 &&  op) return 32'h40000000;
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && !op) return 32'h7F800000;
    if (a == 32'h00800001 && b == 32'h00800000 &&  op) return 32'h00000001;
    return a ^ {b[15:0], b[31:16]} ^ {31'd0, op};
  endfunction

  function automatic logic dp_ovf(input logic [31:0] a, input logic [31:0] b, input logic op);
    return (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && !op);
  endfunction

  function automatic logic dp_unf(input logic [31:0] a, input logic [31:0] b, input logic op);
    return (a == 32'h00800001 && b == 32'h00800000 && op);
  endfunction

  assign ia.dp_r         = dp_res(ia.dp_a, ia.dp_b, ia.dp_op);
  assign ia.dp_overflow  = dp_ovf(ia.dp_a, ia.dp_b, ia.dp_op);
  assign ia.dp_underflow = dp_unf(ia.dp_a, ia.dp_b, ia.dp_op);
  assign ib.dp_r         = dp_res(ib.dp_a, ib.dp_b, ib.dp_op);
  assign ib.dp_overflow  = dp_ovf(ib.dp_a, ib.dp_b, ib.dp_op);
  assign ib.dp_underflow = dp_unf(ib.dp_a, ib.dp_b, ib.dp_op);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input bit use_b, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((use_b ? ib.req_ready : ia.req_ready) != 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Ticks until a response shows up; drop clears the listed valids once the grant edge has passed.
  task automatic wait_rsp(input bit use_b, input logic [1:0] drop, output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 30) begin
      tick();
      lat++;
      if (use_b) ib.req_valid = ib.req_valid & ~drop;
      else       ia.req_valid = ia.req_valid & ~drop;
      ok = ((use_b ? ib.rsp_valid : ia.rsp_valid) != 2'b00);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    ia.req_valid = 2'b11;
    ia.rsp_ready = 2'b00;
    tick();
    tick();
    n_cmp++;
    if (ia.req_ready !== 2'b00) begin
      n_err++; $display("FAIL reset_req_ready: got %b want 00", ia.req_ready);
    end
    n_cmp++;
    if ({ia.rsp_valid, busy_a, gidx_a, ia.dp_op, ia.rsp_overflow, ia.rsp_underflow} !== 7'd0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
                        {ia.rsp_valid, busy_a, gidx_a, ia.dp_op, ia.rsp_overflow, ia.rsp_underflow});
    end
    n_cmp++;
    if ({ia.dp_a, ia.dp_b, ia.rsp_r} !== 96'd0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h want zeros", ia.dp_a, ia.dp_b, ia.rsp_r);
    end
    n_cmp++;
    if (cnt_a !== 16'd0) begin
      n_err++; $display("FAIL reset_op_count: got %0d want 0", cnt_a);
    end
    ia.req_valid = 2'b00;
    rst_a = 1'b0;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    int   lat;
    logic ok;
    ia.req_a = {32'h0, 32'h3F800000};
    ia.req_b = {32'h0, 32'h40000000};
    ia.req_op = 2'b00;
    ia.rsp_ready = 2'b01;
    ia.req_valid = 2'b01;
    #1;
    n_cmp++;
    if (ia.req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_ready: got %b want 01", ia.req_ready);
    end
    sb_a.push_back('{0, 32'h40400000, 1'b0, 1'b0});
    wait_rsp(1'b0, 2'b01, lat, ok);
    n_cmp++;
    if (!ok || lat != 4) begin
      n_err++; $display("FAIL single_latency: got %0d cycles (seen=%b) want 4", lat, ok);
    end
    n_cmp++;
    if (ia.dp_a !== 32'h3F800000 || ia.dp_b !== 32'h40000000 || ia.dp_op !== 1'b0) begin
      n_err++; $display("FAIL single_dp_drive: got %h %h %b want 3f800000 40000000 0", ia.dp_a, ia.dp_b, ia.dp_op);
    end
    e = sb_a.pop_front();
    n_cmp++;
    if ({ia.rsp_valid, gidx_a, ia.rsp_r, ia.rsp_overflow, ia.rsp_underflow} !==
        {2'(1 << e.idx), 1'(e.idx), e.r, e.ovf, e.unf}) begin
      n_err++; $display("FAIL single_rsp: got v=%b g=%0d r=%h o=%b u=%b want v=%b g=%0d r=%h o=%b u=%b",
                        ia.rsp_valid, gidx_a, ia.rsp_r, ia.rsp_overflow, ia.rsp_underflow,
                        2'(1 << e.idx), e.idx, e.r, e.ovf, e.unf);
    end
    $display("txn A req%0d r=%h ovf=%b unf=%b lat=%0d", gidx_a, ia.rsp_r, ia.rsp_overflow, ia.rsp_underflow, lat);
    tick();
    n_cmp++;
    if ({ia.rsp_valid, busy_a, cnt_a} !== {2'b00, 1'b0, 16'd1}) begin
      n_err++; $display("FAIL single_done: got v=%b busy=%b cnt=%0d want v=00 busy=0 cnt=1", ia.rsp_valid, busy_a, cnt_a);
    end
  endtask

  task automatic test_round_robin();
    exp_t       e;
    int         lat;
    logic       ok;
    logic [1:0] exp_oh;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    ia.req_a = {32'h40400000, 32'h3F800000};
    ia.req_b = {32'h3F800000, 32'h40000000};
    ia.req_op = 2'b10;
    ia.rsp_ready = 2'b11;
    ia.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready(1'b0, ok);
      n_cmp++;
      if (!ok || ia.req_ready !== exp_oh) begin
        n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, ia.req_ready, exp_oh);
      end
      sb_a.push_back('{i % 2, (i % 2 == 0) ? 32'h40400000 : 32'h40000000, 1'b0, 1'b0});
      wait_rsp(1'b0, 2'b00, lat, ok);
      e = sb_a.pop_front();
      n_cmp++;
      if ({ok, ia.rsp_valid, gidx_a, ia.rsp_r} !== {1'b1, 2'(1 << e.idx), 1'(e.idx), e.r}) begin
        n_err++; $display("FAIL rr_rsp%0d: got v=%b g=%0d r=%h want v=%b g=%0d r=%h",
                          i, ia.rsp_valid, gidx_a, ia.rsp_r, 2'(1 << e.idx), e.idx, e.r);
      end
      $display("txn A req%0d r=%h ovf=%b unf=%b lat=%0d", gidx_a, ia.rsp_r, ia.rsp_overflow, ia.rsp_underflow, lat);
      if (i == 3) ia.req_valid = 2'b00;
      tick();
    end
    n_cmp++;
    if (cnt_a !== 16'd4) begin
      n_err++; $display("FAIL rr_op_count: got %0d want 4", cnt_a);
    end
  endtask

  task automatic test_hold();
    int   lat;
    logic ok;
    ia.req_a = {32'h40400000, 32'h3F800000};
    ia.req_b = {32'h3F800000, 32'h40000000};
    ia.req_op = 2'b10;
    ia.rsp_ready = 2'b00;
    ia.req_valid = 2'b01;
    #1;
    wait_ready(1'b0, ok);
    sb_a.push_back('{0, 32'h40400000, 1'b0, 1'b0});
    wait_rsp(1'b0, 2'b00, lat, ok);
    n_cmp++;
    if (!ok || lat != 4) begin
      n_err++; $display("FAIL hold_latency: got %0d cycles want 4", lat);
    end
    ia.req_valid = 2'b11;
    ia.rsp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({ia.rsp_valid, ia.rsp_r, ia.req_ready, busy_a} !== {2'b01, 32'h40400000, 2'b00, 1'b1}) begin
        n_err++; $display("FAIL hold_cycle%0d: got v=%b r=%h rdy=%b busy=%b want v=01 r=40400000 rdy=00 busy=1",
                          i, ia.rsp_valid, ia.rsp_r, ia.req_ready, busy_a);
      end
    end
    void'(sb_a.pop_front());
    $display("txn A req%0d r=%h ovf=%b unf=%b held=10", gidx_a, ia.rsp_r, ia.rsp_overflow, ia.rsp_underflow);
    ia.rsp_ready = 2'b01;
    ia.req_valid = 2'b00;
    tick();
    n_cmp++;
    if ({ia.rsp_valid, busy_a, cnt_a} !== {2'b00, 1'b0, 16'd5}) begin
      n_err++; $display("FAIL hold_release: got v=%b busy=%b cnt=%0d want v=00 busy=0 cnt=5", ia.rsp_valid, busy_a, cnt_a);
    end
  endtask

  task automatic test_flags();
    exp_t        e;
    int          lat;
    logic        ok;
    logic [31:0] a, b, er;
    logic        op, eo, eu;
    ia.rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a = 32'h7F7FFFFF; b = 32'h7F7FFFFF; op = 1'b0; er = 32'h7F800000; eo = 1'b1; eu = 1'b0; end
        1:       begin a = 32'h3F800000; b = 32'h40000000; op = 1'b0; er = 32'h40400000; eo = 1'b0; eu = 1'b0; end
        default: begin a = 32'h00800001; b = 32'h00800000; op = 1'b1; er = 32'h00000001; eo = 1'b0; eu = 1'b1; end
      endcase
      ia.req_a[63:32] = a;
      ia.req_b[63:32] = b;
      ia.req_op[1] = op;
      ia.req_valid = 2'b10;
      #1;
      wait_ready(1'b0, ok);
      n_cmp++;
      if (!ok || ia.req_ready !== 2'b10) begin
        n_err++; $display("FAIL flags_grant%0d: got %b want 10", i, ia.req_ready);
      end
      sb_a.push_back('{1, er, eo, eu});
      wait_rsp(1'b0, 2'b10, lat, ok);
      e = sb_a.pop_front();
      n_cmp++;
      if ({ok, ia.rsp_valid, ia.rsp_r, ia.rsp_overflow, ia.rsp_underflow} !==
          {1'b1, 2'(1 << e.idx), e.r, e.ovf, e.unf}) begin
        n_err++; $display("FAIL flags_rsp%0d: got v=%b r=%h o=%b u=%b want v=%b r=%h o=%b u=%b",
                          i, ia.rsp_valid, ia.rsp_r, ia.rsp_overflow, ia.rsp_underflow,
                          2'(1 << e.idx), e.r, e.ovf, e.unf);
      end
      $display("txn A req%0d r=%h ovf=%b unf=%b lat=%0d", gidx_a, ia.rsp_r, ia.rsp_overflow, ia.rsp_underflow, lat);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    logic ok;
    ia.req_a[31:0] = 32'h3F800000;
    ia.req_b[31:0] = 32'h40000000;
    ia.req_op[0] = 1'b0;
    ia.rsp_ready = 2'b11;
    ia.req_valid = 2'b01;
    #1;
    wait_ready(1'b0, ok);
    tick();
    tick();
    n_cmp++;
    if (busy_a !== 1'b1 || ia.rsp_valid !== 2'b00) begin
      n_err++; $display("FAIL rstmid_inflight: got busy=%b v=%b want busy=1 v=00", busy_a, ia.rsp_valid);
    end
    rst_a = 1'b1;
    ia.req_valid = 2'b11;
    tick();
    n_cmp++;
    if ({ia.rsp_valid, ia.req_ready, busy_a, gidx_a, cnt_a, ia.dp_a, ia.dp_b, ia.dp_op, ia.rsp_r,
         ia.rsp_overflow, ia.rsp_underflow} !== 121'd0) begin
      n_err++; $display("FAIL rstmid_outputs: got v=%b rdy=%b busy=%b g=%0d cnt=%0d dpa=%h dpb=%h r=%h want all zero",
                        ia.rsp_valid, ia.req_ready, busy_a, gidx_a, cnt_a, ia.dp_a, ia.dp_b, ia.rsp_r);
    end
    rst_a = 1'b0;
    #1;
    n_cmp++;
    if (ia.req_ready !== 2'b01) begin
      n_err++; $display("FAIL rstmid_priority: got %b want 01", ia.req_ready);
    end
    ia.req_valid = 2'b01;
    sb_a.push_back('{0, 32'h40400000, 1'b0, 1'b0});
    wait_rsp(1'b0, 2'b01, lat, ok);
    e = sb_a.pop_front();
    n_cmp++;
    if ({ok, ia.rsp_valid, ia.rsp_r} !== {1'b1, 2'(1 << e.idx), e.r} || lat != 4) begin
      n_err++; $display("FAIL rstmid_rsp: got v=%b r=%h lat=%0d want v=%b r=%h lat=4",
                        ia.rsp_valid, ia.rsp_r, lat, 2'(1 << e.idx), e.r);
    end
    $display("txn A req%0d r=%h ovf=%b unf=%b lat=%0d", gidx_a, ia.rsp_r, ia.rsp_overflow, ia.rsp_underflow, lat);
    tick();
    n_cmp++;
    if (cnt_a !== 16'd1) begin
      n_err++; $display("FAIL rstmid_op_count: got %0d want 1", cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    int   prev_cyc;
    logic ok;
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    ib.rsp_ready = 2'b11;
    ib.req_valid = 2'b01;
    prev_cyc = 0;
    for (int i = 0; i < 17; i++) begin
      ib.req_a[31:0] = 32'h00001000 + 32'(i);
      ib.req_b[31:0] = 32'(i * 3);
      ib.req_op[0] = i[0];
      #1;
      wait_ready(1'b1, ok);
      n_cmp++;
      if (!ok || ib.req_ready !== 2'b01) begin
        n_err++; $display("FAIL b2b_grant%0d: got %b want 01", i, ib.req_ready);
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc - prev_cyc != 3) begin
          n_err++; $display("FAIL b2b_interval%0d: got %0d cycles want 3", i, cyc - prev_cyc);
        end
      end
      prev_cyc = cyc;
      sb_b.push_back('{0, dp_res(32'h00001000 + 32'(i), 32'(i * 3), i[0]), 1'b0, 1'b0});
      wait_rsp(1'b1, 2'b00, lat, ok);
      e = sb_b.pop_front();
      n_cmp++;
      if ({ok, ib.rsp_valid, gidx_b, ib.rsp_r} !== {1'b1, 2'(1 << e.idx), 1'(e.idx), e.r} || lat != 2) begin
        n_err++; $display("FAIL b2b_rsp%0d: got v=%b r=%h lat=%0d want v=%b r=%h lat=2",
                          i, ib.rsp_valid, ib.rsp_r, lat, 2'(1 << e.idx), e.r);
      end
      $display("txn B req%0d r=%h ovf=%b unf=%b lat=%0d", gidx_b, ib.rsp_r, ib.rsp_overflow, ib.rsp_underflow, lat);
      if (i == 16) ib.req_valid = 2'b00;
      tick();
    end
    n_cmp++;
    if (cnt_b !== 4'd1) begin
      n_err++; $display("FAIL b2b_op_count_wrap: got %0d want 1", cnt_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia.req_valid = 2'b00; ia.req_a = '0; ia.req_b = '0; ia.req_op = '0; ia.rsp_ready = 2'b00;
    ib.req_valid = 2'b00; ib.req_a = '0; ib.req_b = '0; ib.req_op = '0; ib.rsp_ready = 2'b00;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_flags();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
